unary_stream_decoder: RTL and testbench
=======================================

Name: unary_stream_decoder

Overview:
- Converts a unary (stochastic) bitstream back to binary: counts 1s over a fixed window of 2^BITWIDTH enabled samples and presents the count with a valid/ack handshake.
- Sits at the output of the unary multiplier chain.
- Consumes the multiplier's `mult` stream, qualified by the same enable, and hands a binary product to downstream logic.

Parameters:
- BITWIDTH, 8, width of the binary result; window length = 2^BITWIDTH enabled samples.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iStart  input  1  request to open a new window; one-cycle pulse.
- iEn  input  1  the sample on iBit is valid this cycle.
- iBit  input  1  unary stream bit.
- iClr  input  1  synchronous abort/clear.
- iAck  input  1  consumer accepts oCnt.
- oBusy  output  1  window in progress.
- oValid  output  1  oCnt holds a completed result.
- oCnt  output  BITWIDTH  count of 1s in the last window, saturated.

Behaviour:
- Reset (iRst=1, async):
  - state=IDLE; sample counter=0; ones accumulator=0.
  - oBusy=0, oValid=0, oCnt=0.
- States:
  - IDLE: wait for iStart.
  - ACCUM: counting samples.
  - DONE: result held until acknowledged.
- IDLE:
  - iStart=1 -> ACCUM next cycle; sample counter and accumulator zeroed.
  - iBit in the iStart cycle is not sampled.
- ACCUM:
  - oBusy=1.
  - Each cycle with iEn=1: sample counter +1, accumulator +iBit.
  - Cycles with iEn=0 leave all counters unchanged; window length is in enabled samples, not cycles.
  - iStart is ignored.
- Window end:
  - The enabled sample taken when the sample counter equals 2^BITWIDTH-1 is the last one.
  - Next cycle: state=DONE, oValid=1, oBusy=0.
  - oCnt = min(accumulator incl. last bit, 2^BITWIDTH-1).
- Width rule:
  - Accumulator is BITWIDTH+1 bits.
  - A full-ones window (2^BITWIDTH) saturates to all-ones; no wrap.
- DONE:
  - oValid and oCnt are held stable until iAck=1.
  - iAck=1 -> IDLE next cycle; oValid=0; oCnt retains its value.
- iAck and iStart in the same DONE cycle -> directly to ACCUM with counters zeroed; oValid drops.
- iAck outside DONE is ignored.
- iClr=1, any state:
  - Next cycle: IDLE, counters zeroed, oValid=0, oBusy=0, oCnt=0.
  - iClr has priority over iStart, iAck and the window-end transition.
- iRst asserted mid-window: immediate return to reset values; the partial count is discarded.
- Latency: oValid rises exactly 1 cycle after the final enabled sample.

Decomposition:
- Package unary_pkg:
  - state enum typedef {IDLE, ACCUM, DONE}.
  - Localparam function for window length 2^BITWIDTH.
  - Saturation helper returning a BITWIDTH-bit value.
- Sub-module unary_ones_counter:
  - Holds the sample counter and the BITWIDTH+1-bit accumulator.
  - Inputs: clear, enable, bit. Outputs: last_sample flag, raw count.
  - The FSM and the output register stay in the top module.

Test Plan:
- Reset: iRst=1 for 2 cycles with iStart/iEn toggling -> oBusy=0, oValid=0, oCnt=0 throughout.
- Alternating stream: iStart, then iEn=1 with iBit=1,0,1,0… for 256 cycles -> oValid rises on cycle 257, oCnt=128; held for 5 cycles without iAck; iAck -> oValid=0 next cycle.
- All ones: 256 enabled 1s -> oCnt=255 (saturated). All zeros -> oCnt=0.
- Gapped enable: iEn toggled every other cycle, iBit=1 only when iEn=1 on 64 samples -> done after 512 cycles, oCnt=64; iBit=1 during iEn=0 cycles has no effect.
- Abort: iClr at sample 100 -> IDLE next cycle, oBusy=0, oValid=0. Repeat with iRst mid-window -> immediate reset values. A fresh iStart afterwards gives the correct count.
- Back-to-back: in DONE assert iAck and iStart together -> oValid drops, oBusy=1 next cycle; second window of 32 ones -> oCnt=32.

Source files
------------

// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and helpers for the unary stream decoder
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of enabled samples in one window.
  function automatic int unsigned windowLen(input int unsigned bw);
    return 32'd1 << bw;
  endfunction

  // Clamp a raw ones count to the largest value a bw-bit result can hold.
  function automatic logic [31:0] satCount(input logic [31:0] acc, input int unsigned bw);
    logic [31:0] maxVal;
    maxVal = (32'd1 << bw) - 32'd1;
    return (acc > maxVal) ? maxVal : acc;
  endfunction

endpackage

// File: rtl/unary_ones_counter.sv
// rtl/unary_ones_counter.sv - sample counter and ones accumulator for one window
module unary_ones_counter
  import unary_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              bitIn,
  output logic              lastSample,
  output logic [BITWIDTH:0] count
);

  localparam int unsigned WIN = windowLen(BITWIDTH);
  localparam logic [BITWIDTH-1:0] LAST_IDX = BITWIDTH'(WIN - 1);

  logic [BITWIDTH-1:0] sampleCnt;

  // Count enabled samples and accumulate ones; the extra accumulator bit holds a full-ones window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleCnt <= '0;
      count     <= '0;
    end else if (clear) begin
      sampleCnt <= '0;
      count     <= '0;
    end else if (en) begin
      sampleCnt <= sampleCnt + 1'b1;
      count     <= count + (BITWIDTH + 1)'(bitIn);
    end
  end

  assign lastSample = (sampleCnt == LAST_IDX);

endmodule

// File: rtl/unary_stream_decoder.sv
// rtl/unary_stream_decoder.sv - counts ones over a 2^BITWIDTH sample window with valid/ack
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  input  logic                iEn,
  input  logic                iBit,
  input  logic                iClr,
  input  logic                iAck,
  output logic                oBusy,
  output logic                oValid,
  output logic [BITWIDTH-1:0] oCnt
);

  state_t state, stateNext;

  logic              lastSample;
  logic [BITWIDTH:0] onesRaw;
  logic [BITWIDTH:0] onesFinal;
  logic              ctrClear;
  logic              ctrEn;
  logic              windowEnd;

  // A new window opens from IDLE, or straight from DONE when ack and start coincide.
  assign ctrClear  = iClr || (state == IDLE && iStart) || (state == DONE && iAck && iStart);
  assign ctrEn     = (state == ACCUM) && iEn && !iClr;
  assign windowEnd = ctrEn && lastSample;
  // The final sample is still in flight, so fold it into the captured total.
  assign onesFinal = onesRaw + (BITWIDTH + 1)'(iBit);

  unary_ones_counter #(
    .BITWIDTH(BITWIDTH)
  ) uCounter (
    .clk       (iClk),
    .rst       (iRst),
    .clear     (ctrClear),
    .en        (ctrEn),
    .bitIn     (iBit),
    .lastSample(lastSample),
    .count     (onesRaw)
  );

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    stateNext = state;
    if (iClr) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (iStart) stateNext = ACCUM;
        ACCUM:   if (windowEnd) stateNext = DONE;
        DONE:    if (iAck) stateNext = iStart ? ACCUM : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Result register: captured at window end, kept after ack, zeroed by clear.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (windowEnd) begin
      oCnt <= BITWIDTH'(satCount(32'(onesFinal), BITWIDTH));
    end
  end

  assign oBusy  = (state == ACCUM);
  assign oValid = (state == DONE);

endmodule

// File: tb/tb_unary_stream_decoder.sv
// tb/tb_unary_stream_decoder.sv - directed table-driven bench for unary_stream_decoder
module tb_unary_stream_decoder;

  localparam int BW  = 8;
  localparam int WIN = 256;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          iStart = 1'b0;
  logic          iEn = 1'b0;
  logic          iBit = 1'b0;
  logic          iClr = 1'b0;
  logic          iAck = 1'b0;
  logic          oBusy;
  logic          oValid;
  logic [BW-1:0] oCnt;

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    string name;
    int    pat;
    bit    gapped;
    int    expCnt;
  } vec_t;

  vec_t vecs[5];

  unary_stream_decoder #(.BITWIDTH(BW)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iStart(iStart),
    .iEn   (iEn),
    .iBit  (iBit),
    .iClr  (iClr),
    .iAck  (iAck),
    .oBusy (oBusy),
    .oValid(oValid),
    .oCnt  (oCnt)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic checkOut(input string name, input bit busy, input bit valid, input int cnt);
    check({name, ".busy"}, 32'(oBusy), 32'(busy));
    check({name, ".valid"}, 32'(oValid), 32'(valid));
    check({name, ".cnt"}, 32'(oCnt), 32'(cnt));
  endtask

  function automatic bit patBit(input int pat, input int i);
    case (pat)
      0:       return (i % 2) == 0;
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return i < 64;
      4:       return (i % 4) == 0;
      5:       return i < 32;
      default: return 1'b0;
    endcase
  endfunction

  // iBit=1 in the start cycle must not be counted.
  task automatic startWindow();
    iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
  endtask

  // Feed samples [0, n); noise drives iBit=1 on disabled cycles plus stray iStart/iAck.
  task automatic feed(input int pat, input bit gapped, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        iEn = 1'b0; iBit = 1'b1;
        tick();
      end
      iEn = 1'b1; iBit = patBit(pat, i);
      if (i == WIN - 1) begin
        check({name, ".preBusy"}, 32'(oBusy), 32'd1);
        check({name, ".preValid"}, 32'(oValid), 32'd0);
      end
      tick();
    end
    iEn = 1'b0; iBit = 1'b0;
  endtask

  task automatic ack();
    iAck = 1'b1;
    tick();
    iAck = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"alternating", 0, 1'b0, 128};
    vecs[1] = '{"allOnes",     1, 1'b0, 255};
    vecs[2] = '{"allZeros",    2, 1'b0, 0};
    vecs[3] = '{"gapped64",    3, 1'b1, 64};
    vecs[4] = '{"gappedQuarter", 4, 1'b1, 64};

    // Reset with inputs toggling.
    iRst = 1'b1;
    #1;
    checkOut("rstAsync", 1'b0, 1'b0, 0);
    for (int c = 0; c < 2; c++) begin
      iStart = c[0]; iEn = ~c[0]; iBit = 1'b1;
      tick();
      checkOut("rstHold", 1'b0, 1'b0, 0);
    end
    iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
    iRst = 1'b0;
    tick();
    checkOut("postRst", 1'b0, 1'b0, 0);

    // Table-driven windows.
    for (int v = 0; v < 5; v++) begin
      startWindow();
      check({vecs[v].name, ".busyAfterStart"}, 32'(oBusy), 32'd1);
      feed(vecs[v].pat, vecs[v].gapped, WIN, vecs[v].name);
      checkOut({vecs[v].name, ".done"}, 1'b0, 1'b1, vecs[v].expCnt);
      for (int h = 0; h < 5; h++) begin
        tick();
        checkOut({vecs[v].name, ".hold"}, 1'b0, 1'b1, vecs[v].expCnt);
      end
      ack();
      checkOut({vecs[v].name, ".acked"}, 1'b0, 1'b0, vecs[v].expCnt);
    end

    // Abort with iClr at sample 100.
    startWindow();
    feed(1, 1'b0, 100, "clr");
    iClr = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iClr = 1'b0; iEn = 1'b0; iBit = 1'b0;
    checkOut("clrAbort", 1'b0, 1'b0, 0);
    tick();
    checkOut("clrIdle", 1'b0, 1'b0, 0);

    // Fresh window after clear.
    startWindow();
    feed(1, 1'b0, WIN, "afterClr");
    checkOut("afterClr.done", 1'b0, 1'b1, 255);
    ack();

    // iRst mid-window discards the partial count immediately.
    startWindow();
    feed(1, 1'b0, 50, "rstMid");
    #2;
    iRst = 1'b1;
    #1;
    checkOut("rstMidAsync", 1'b0, 1'b0, 0);
    tick();
    iRst = 1'b0;
    tick();
    checkOut("rstMidIdle", 1'b0, 1'b0, 0);
    startWindow();
    feed(0, 1'b0, WIN, "afterRst");
    checkOut("afterRst.done", 1'b0, 1'b1, 128);

    // iClr on the final sample wins over the window-end transition.
    iAck = 1'b1; iStart = 1'b1;
    tick();
    iAck = 1'b0; iStart = 1'b0;
    feed(1, 1'b0, WIN - 1, "clrLast");
    iClr = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iClr = 1'b0; iEn = 1'b0; iBit = 1'b0;
    checkOut("clrLast", 1'b0, 1'b0, 0);

    // Back-to-back: ack+start in DONE, stray iStart/iAck in ACCUM are ignored.
    startWindow();
    feed(1, 1'b0, WIN, "b2bFirst");
    checkOut("b2bFirst.done", 1'b0, 1'b1, 255);
    iAck = 1'b1; iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
    tick();
    iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
    checkOut("b2bRestart", 1'b1, 1'b0, 255);
    iStart = 1'b1;
    feed(5, 1'b0, WIN, "b2bSecond");
    iAck = 1'b0; iStart = 1'b0;
    checkOut("b2bSecond.done", 1'b0, 1'b1, 32);
    ack();
    checkOut("b2bAcked", 1'b0, 1'b0, 32);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
